// File: rtl/confreg_lite.sv
// confreg_lite: peripheral register window (LED, NUM, scratch, timer, switch) with 1-cycle read latency
module confreg_lite #(
  parameter logic [15:0] BASE_HI   = 16'hBFAF,
  parameter logic [31:0] TIMER_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data,
  output logic [31:0] timer_out
);
  localparam logic [15:0] OFF_SCRATCH = 16'hF000;
  localparam logic [15:0] OFF_LED     = 16'hF020;
  localparam logic [15:0] OFF_NUM     = 16'hF050;
  localparam logic [15:0] OFF_SWITCH  = 16'hF060;
  localparam logic [15:0] OFF_TIMER   = 16'hF0E0;

  logic [31:0] scratch_q, scratch_d, num_q, num_d, timer_q, timer_d, rdata_q, rdata_d, rd_mux;
  logic [15:0] led_q, led_d, off;
  logic [7:0]  sw_meta_q, sw_sync_q;
  logic        hit, wr, rd;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    for (int i = 0; i < 4; i++) merge[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
  endfunction

  assign hit = data_sram_en && data_sram_addr[31:16] == BASE_HI;
  assign wr  = hit && |data_sram_wen;
  assign rd  = hit && data_sram_wen == 4'b0000;
  assign off = {data_sram_addr[15:2], 2'b00};

  always_comb begin
    rd_mux    = off == OFF_SCRATCH ? scratch_q :
                off == OFF_LED     ? {16'b0, led_q} :
                off == OFF_NUM     ? num_q :
                off == OFF_SWITCH  ? {24'b0, sw_sync_q} :
                off == OFF_TIMER   ? timer_q : 32'h0;
    rdata_d   = rd ? rd_mux : rdata_q;
    scratch_d = wr && off == OFF_SCRATCH ? merge(scratch_q, data_sram_wdata, data_sram_wen) : scratch_q;
    num_d     = wr && off == OFF_NUM ? merge(num_q, data_sram_wdata, data_sram_wen) : num_q;
    led_d     = wr && off == OFF_LED ? merge({16'b0, led_q}, data_sram_wdata, {2'b00, data_sram_wen[1:0]}) : led_q;
    // a timer write replaces the increment for that cycle
    timer_d   = wr && off == OFF_TIMER ? merge(timer_q, data_sram_wdata, data_sram_wen) : timer_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scratch_q <= '0;
      led_q     <= '0;
      num_q     <= '0;
      timer_q   <= TIMER_RST;
      rdata_q   <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      scratch_q <= scratch_d;
      led_q     <= led_d;
      num_q     <= num_d;
      timer_q   <= timer_d;
      rdata_q   <= rdata_d;
      sw_meta_q <= switch;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign num_data        = num_q;
  assign timer_out       = timer_q;
endmodule

// File: tb/tb_confreg_lite.sv
// tb_confreg_lite: directed checks of register access, byte merge, timer, switch sync and reset
module tb_confreg_lite;
  logic        clk = 0, rst = 1, en = 0;
  logic [3:0]  wen = 0;
  logic [31:0] addr = 0, wdata = 0, rdata, num_data, timer_out;
  logic [7:0]  sw = 0;
  logic [15:0] led;
  int total = 0, passed = 0;

  localparam logic [31:0] A_SCR = 32'hBFAF_F000, A_LED = 32'hBFAF_F020, A_NUM = 32'hBFAF_F050,
                          A_SW = 32'hBFAF_F060, A_TMR = 32'hBFAF_F0E0;

  confreg_lite dut (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .data_sram_rdata(rdata), .switch(sw), .led(led),
    .num_data(num_data), .timer_out(timer_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    tick(); tick();
    chk("rst_rdata", rdata, 0);
    chk("rst_led", {16'b0, led}, 0);
    chk("rst_num", num_data, 0);
    chk("rst_timer", timer_out, 0);
    rst = 0; acc(1, 4'h0, A_LED, 0); tick();
    chk("read_led_after_rst", rdata, 0);
    chk("timer_1", timer_out, 1);
    acc(0, 4'h0, 0, 0); tick();
    chk("timer_2", timer_out, 2);
    acc(1, 4'hF, A_NUM, 32'h1234_5678); tick();
    chk("num_full", num_data, 32'h1234_5678);
    acc(1, 4'b0101, A_NUM, 32'hAABB_CCDD); tick();
    chk("num_merge", num_data, 32'h12BB_56DD);
    acc(1, 4'h0, A_NUM, 0); tick();
    chk("read_num", rdata, 32'h12BB_56DD);
    acc(1, 4'hF, A_LED, 32'hFFFF_0F0F); tick();
    chk("led_write", {16'b0, led}, 32'h0000_0F0F);
    acc(1, 4'h0, A_LED, 0); tick();
    chk("read_led", rdata, 32'h0000_0F0F);
    acc(1, 4'hF, A_SCR, 32'hCAFE_F00D); tick();
    acc(1, 4'h0, A_SCR, 0); tick();
    chk("read_scratch", rdata, 32'hCAFE_F00D);
    acc(1, 4'hF, A_TMR, 32'hFFFF_FFFE); tick();
    chk("timer_load", timer_out, 32'hFFFF_FFFE);
    acc(0, 4'h0, 0, 0); tick();
    chk("timer_ff", timer_out, 32'hFFFF_FFFF);
    acc(1, 4'h0, A_TMR, 0); tick();
    chk("timer_wrap", timer_out, 0);
    chk("read_timer", rdata, 32'hFFFF_FFFF);
    sw = 8'hA5; acc(1, 4'h0, A_SW, 0); tick();
    chk("sw_before_E", rdata, 0);
    tick();
    chk("sw_before_E1", rdata, 0);
    tick();
    chk("sw_synced", rdata, 32'h0000_00A5);
    acc(1, 4'hF, 32'hBFAE_F050, 32'h1111_1111); tick();
    chk("miss_write", num_data, 32'h12BB_56DD);
    acc(1, 4'h0, 32'hBFAF_F100, 0); tick();
    chk("unmapped_read", rdata, 0);
    acc(1, 4'hF, 32'hBFAF_F100, 32'h5555_5555); tick();
    chk("unmapped_write", rdata, 0);
    acc(1, 4'h0, A_NUM, 0); tick();
    chk("read_num2", rdata, 32'h12BB_56DD);
    acc(0, 4'h0, A_LED, 0); tick();
    chk("en0_hold", rdata, 32'h12BB_56DD);
    acc(1, 4'hF, A_LED, 32'h0000_1234); tick();
    chk("write_keeps_rdata", rdata, 32'h12BB_56DD);
    rst = 1; acc(1, 4'hF, A_NUM, 32'hDEAD_BEEF); tick();
    chk("midrst_num", num_data, 0);
    chk("midrst_rdata", rdata, 0);
    chk("midrst_led", {16'b0, led}, 0);
    chk("midrst_timer", timer_out, 0);
    rst = 0; acc(1, 4'h0, A_NUM, 0); tick();
    chk("read_after_midrst", rdata, 0);
    acc(1, 4'h0, A_SCR, 0); tick();
    chk("scratch_after_rst", rdata, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
